// File: rtl/dlfloat16_pkg.sv
// dlfloat16 format constants shared by the SIMD multiplier.
// Layout: sign[15], exp[14:9] (bias 31), mant[8:0]. exp==0 is zero (flush-to-zero),
// exp==63 is inf (mant==0) or NaN (mant!=0).
package dlfloat16_pkg;

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned MAN_W  = 9;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;

  localparam logic [EXP_W-1:0] BIAS        = 6'd31;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 6'd63;
  localparam logic [15:0]      QNAN        = 16'h7FFF;
  localparam logic [14:0]      MAX_NORM    = 15'h7DFF;

  // Rounding modes
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Exception vector bit positions: {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int unsigned EXC_NV = 4;
  localparam int unsigned EXC_DZ = 3;
  localparam int unsigned EXC_OF = 2;
  localparam int unsigned EXC_UF = 1;
  localparam int unsigned EXC_NX = 0;

  // Result class decided in S1 from the operands alone
  typedef enum logic [2:0] {
    ClsNorm,
    ClsZero,
    ClsInf,
    ClsNan,
    ClsInvalid
  } res_cls_e;

endpackage

// File: rtl/dlfloat16_mul_lane.sv
// One dlfloat16 multiply lane: S1 unpack/classify, S2 significand product and
// exponent sum, S3 normalise/round/pack. All stage flops advance together on adv_i.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   adv_i       pipeline advance (shared by all lanes)
//   a_i, b_i    operands entering S1
//   rm_i        rounding mode of the bundle currently held in S2
//   res_o       packed product (S3 register)
//   excep_o     {invalid, div_by_zero, overflow, underflow, inexact} (S3 register)
module dlfloat16_mul_lane
  import dlfloat16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [2:0]  rm_i,
  output logic [15:0] res_o,
  output logic [4:0]  excep_o
);

  // ---------------- S1: unpack and classify ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  res_cls_e         cls_d;

  assign ea     = a_i[14:9];
  assign eb     = b_i[14:9];
  assign ma     = a_i[8:0];
  assign mb     = b_i[8:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EXP_SPECIAL) && (ma == '0);
  assign inf_b  = (eb == EXP_SPECIAL) && (mb == '0);
  assign nan_a  = (ea == EXP_SPECIAL) && (ma != '0);
  assign nan_b  = (eb == EXP_SPECIAL) && (mb != '0);

  always_comb begin
    cls_d = ClsNorm;
    if (nan_a || nan_b) begin
      cls_d = ClsNan;
    end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
      cls_d = ClsInvalid;
    end else if (inf_a || inf_b) begin
      cls_d = ClsInf;
    end else if (zero_a || zero_b) begin
      cls_d = ClsZero;
    end
  end

  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_ea_q, s1_eb_q;
  logic [SIG_W-1:0] s1_siga_q, s1_sigb_q;
  res_cls_e         s1_cls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign_q <= 1'b0;
      s1_ea_q   <= '0;
      s1_eb_q   <= '0;
      s1_siga_q <= '0;
      s1_sigb_q <= '0;
      s1_cls_q  <= ClsZero;
    end else if (adv_i) begin
      s1_sign_q <= a_i[15] ^ b_i[15];
      s1_ea_q   <= ea;
      s1_eb_q   <= eb;
      s1_siga_q <= {1'b1, ma};
      s1_sigb_q <= {1'b1, mb};
      s1_cls_q  <= cls_d;
    end
  end

  // ---------------- S2: product and exponent sum ----------------
  logic [PROD_W-1:0] s2_prod_d;
  logic signed [7:0] s2_exp_d;

  assign s2_prod_d = PROD_W'(s1_siga_q) * PROD_W'(s1_sigb_q);
  assign s2_exp_d  = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q})
                   - $signed({2'b00, BIAS});

  logic              s2_sign_q;
  logic [PROD_W-1:0] s2_prod_q;
  logic signed [7:0] s2_exp_q;
  res_cls_e          s2_cls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign_q <= 1'b0;
      s2_prod_q <= '0;
      s2_exp_q  <= '0;
      s2_cls_q  <= ClsZero;
    end else if (adv_i) begin
      s2_sign_q <= s1_sign_q;
      s2_prod_q <= s2_prod_d;
      s2_exp_q  <= s2_exp_d;
      s2_cls_q  <= s1_cls_q;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic              prod_hi, guard, sticky, inc, to_inf;
  logic [MAN_W-1:0]  mant;
  logic [MAN_W:0]    mant_sum;
  logic signed [7:0] exp_n, exp_r;
  logic [15:0]       res_d;
  logic [4:0]        exc_d;

  always_comb begin
    prod_hi = s2_prod_q[PROD_W-1];
    // Product of two [1,2) significands lies in [1,4); bit 19 means >= 2.
    if (prod_hi) begin
      mant   = s2_prod_q[18:10];
      guard  = s2_prod_q[9];
      sticky = |s2_prod_q[8:0];
    end else begin
      mant   = s2_prod_q[17:9];
      guard  = s2_prod_q[8];
      sticky = |s2_prod_q[7:0];
    end
    exp_n = s2_exp_q + $signed({7'b0, prod_hi});

    case (rm_i)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (guard | sticky) & s2_sign_q;
      RM_RUP:  inc = (guard | sticky) & ~s2_sign_q;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase

    case (rm_i)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s2_sign_q;
      RM_RUP:  to_inf = ~s2_sign_q;
      default: to_inf = 1'b1;
    endcase

    // Carry out of the 9-bit mantissa leaves mant_sum[8:0] == 0 and bumps the exponent.
    mant_sum = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    exp_r    = exp_n + $signed({7'b0, mant_sum[MAN_W]});

    res_d = '0;
    exc_d = '0;
    case (s2_cls_q)
      ClsNan: res_d = QNAN;
      ClsInvalid: begin
        res_d         = QNAN;
        exc_d[EXC_NV] = 1'b1;
      end
      ClsInf:  res_d = {s2_sign_q, EXP_SPECIAL, {MAN_W{1'b0}}};
      ClsZero: res_d = {s2_sign_q, 15'd0};
      default: begin
        if (exp_r >= 8'sd63) begin
          res_d         = to_inf ? {s2_sign_q, EXP_SPECIAL, {MAN_W{1'b0}}}
                                 : {s2_sign_q, MAX_NORM};
          exc_d[EXC_OF] = 1'b1;
          exc_d[EXC_NX] = 1'b1;
        end else if (exp_r <= 8'sd0) begin
          res_d         = {s2_sign_q, 15'd0};
          exc_d[EXC_UF] = 1'b1;
          exc_d[EXC_NX] = 1'b1;
        end else begin
          res_d         = {s2_sign_q, exp_r[EXP_W-1:0], mant_sum[MAN_W-1:0]};
          exc_d[EXC_NX] = guard | sticky;
        end
      end
    endcase
  end

  logic [15:0] res_q;
  logic [4:0]  exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      exc_q <= '0;
    end else if (adv_i) begin
      res_q <= res_d;
      exc_q <= exc_d;
    end
  end

  assign res_o   = res_q;
  assign excep_o = exc_q;

endmodule

// File: rtl/dlfloat16_mul_pipe.sv
// LANES-wide SIMD dlfloat16 multiplier, fixed 3-stage pipeline, valid/ready handshake.
// A bundle accepted at cycle t is presented at t+3 without back-pressure; the whole
// pipe stalls while the output is held (bubbles are not squeezed).
// Build option: DLFP_MUL_DYN_RM_EN honours in_rm; otherwise every lane rounds RNE and
// in_rm is ignored.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready independent of in_valid)
//   in_a, in_b              lane i operands at [16i+15:16i]
//   in_rm                   rounding mode, in_tag sideband returned as out_tag
//   out_valid/out_ready     output handshake
//   out_res, out_excep      per-lane product and {NV, DZ, OF, UF, NX}
//   fflags, flags_clr       sticky OR of delivered exceptions and its clear
module dlfloat16_mul_pipe
  import dlfloat16_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [16*LANES-1:0] in_a,
  input  logic [16*LANES-1:0] in_b,
  input  logic [2:0]         in_rm,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [16*LANES-1:0] out_res,
  output logic [TAG_W-1:0]   out_tag,
  output logic [5*LANES-1:0] out_excep,
  output logic [4:0]         fflags,
  input  logic               flags_clr
);

  logic             adv;
  logic             s1_valid_q, s2_valid_q, s3_valid_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  logic [2:0]       lane_rm;

  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s1_tag_q   <= in_tag;
      s2_tag_q   <= s1_tag_q;
      s3_tag_q   <= s2_tag_q;
    end
  end

`ifdef DLFP_MUL_DYN_RM_EN
  // Rounding is applied between S2 and S3, so the lanes see the S2 copy.
  logic [2:0] s1_rm_q, s2_rm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rm_q <= RM_RNE;
      s2_rm_q <= RM_RNE;
    end else if (adv) begin
      s1_rm_q <= in_rm;
      s2_rm_q <= s1_rm_q;
    end
  end

  assign lane_rm = s2_rm_q;
`else
  logic [2:0] unused_rm;

  assign unused_rm = in_rm;
  assign lane_rm   = RM_RNE;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dlfloat16_mul_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv_i   (adv),
      .a_i     (in_a[16*i +: 16]),
      .b_i     (in_b[16*i +: 16]),
      .rm_i    (lane_rm),
      .res_o   (out_res[16*i +: 16]),
      .excep_o (out_excep[5*i +: 5])
    );
  end

  logic [4:0] excep_any;
  logic [4:0] fflags_d, fflags_q;

  always_comb begin
    excep_any = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      excep_any = excep_any | out_excep[5*i +: 5];
    end
  end

  // Clear takes effect before the same-cycle delivery is merged, so nothing is lost.
  always_comb begin
    fflags_d = flags_clr ? 5'd0 : fflags_q;
    if (s3_valid_q && out_ready) begin
      fflags_d = fflags_d | excep_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_tag   = s3_tag_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_dlfloat16_mul_pipe.sv
`timescale 1ns/1ps
module tb_dlfloat16_mul_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned TAG_W = 8;
`ifdef DLFP_MUL_DYN_RM_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_ready, out_valid, out_ready, flags_clr;
  logic [16*LANES-1:0]   in_a, in_b, out_res;
  logic [2:0]            in_rm;
  logic [TAG_W-1:0]      in_tag, out_tag;
  logic [5*LANES-1:0]    out_excep;
  logic [4:0]            fflags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dlfloat16_mul_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_excep (out_excep),
    .fflags    (fflags),
    .flags_clr (flags_clr)
  );

  typedef struct {
    logic [63:0] res;
    logic [19:0] exc;
    logic [7:0]  tag;
  } sb_t;

  // ---------------- reference model ----------------
  function automatic logic [2:0] eff_rm(input logic [2:0] rm);
    if (!DYN || rm > 3'd4) return 3'd0;
    return rm;
  endfunction

  // Exact integer product; rounding judged by comparing the discarded remainder to half an ulp.
  function automatic logic [20:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] rm);
    int ea, eb, ma, mb, p, msb, drop, keep, rem, half, e;
    logic s;
    logic [2:0] m;
    bit up, to_inf;
    ea = int'(a[14:9]);
    eb = int'(b[14:9]);
    ma = int'(a[8:0]);
    mb = int'(b[8:0]);
    s  = a[15] ^ b[15];
    m  = eff_rm(rm);
    if ((ea == 63 && ma != 0) || (eb == 63 && mb != 0)) return {5'b00000, 16'h7FFF};
    if ((ea == 0 && eb == 63) || (ea == 63 && eb == 0)) return {5'b10000, 16'h7FFF};
    if (ea == 63 || eb == 63) return {5'b00000, s, 15'h7E00};
    if (ea == 0 || eb == 0) return {5'b00000, s, 15'h0000};
    p = (512 + ma) * (512 + mb);
    msb = 0;
    for (int i = 0; i < 20; i++) if (((p >> i) & 1) == 1) msb = i;
    drop = msb - 9;
    keep = p >> drop;
    rem  = p - (keep << drop);
    half = 1 << (drop - 1);
    e    = ea + eb - 31 + (msb - 18);
    case (m)
      3'd0:    up = (rem > half) || (rem == half && (keep % 2) == 1);
      3'd1:    up = 1'b0;
      3'd2:    up = (rem != 0) && s;
      3'd3:    up = (rem != 0) && !s;
      default: up = (rem >= half);
    endcase
    if (up) keep++;
    if (keep == 1024) begin
      keep = 512;
      e++;
    end
    if (e >= 63) begin
      to_inf = (m == 0) || (m == 4) || (m == 2 && s) || (m == 3 && !s);
      return {5'b00101, s, to_inf ? 15'h7E00 : 15'h7DFF};
    end
    if (e <= 0) return {5'b00011, s, 15'h0000};
    return {4'b0000, rem != 0, s, e[5:0], keep[8:0]};
  endfunction

  function automatic sb_t ref_bundle(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] rm, input logic [7:0] tag);
    sb_t r;
    logic [20:0] l;
    for (int i = 0; i < 4; i++) begin
      l = ref_mul(a[16*i +: 16], b[16*i +: 16], rm);
      r.res[16*i +: 16] = l[15:0];
      r.exc[5*i +: 5]   = l[20:16];
    end
    r.tag = tag;
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [5:0] e;
    logic [8:0] m;
    int k;
    k = $urandom_range(0, 15);
    e = (k == 0) ? 6'd0 : (k == 1) ? 6'd63 : 6'($urandom_range(1, 62));
    m = 9'($urandom);
    if (k == 1 && $urandom_range(0, 1) == 0) m = 9'd0;
    return {1'($urandom), e, m};
  endfunction

  // ---------------- drivers ----------------
  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                      input logic [7:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_rm    = rm;
    in_tag   = tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_res, out_tag, out_excep, fflags} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b res=%h tag=%h exc=%h ff=%b want all zero",
               out_valid, out_res, out_tag, out_excep, fflags);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] ta[6], tb[6], te_dyn[6], te_rne[6], want;
    logic [19:0] tx[6];
    logic [2:0]  tr[6];
    int lat;
    ta[0] = {4{16'h3F00}}; tb[0] = {4{16'h4000}}; tr[0] = 3'd0;
    te_dyn[0] = {4{16'h4100}}; te_rne[0] = {4{16'h4100}}; tx[0] = 20'h0;
    ta[1] = {4{16'h3E01}}; tb[1] = {4{16'h3E01}}; tr[1] = 3'd0;
    te_dyn[1] = {4{16'h3E02}}; te_rne[1] = {4{16'h3E02}}; tx[1] = 20'h08421;
    ta[2] = ta[1]; tb[2] = tb[1]; tr[2] = 3'd1;
    te_dyn[2] = {4{16'h3E02}}; te_rne[2] = {4{16'h3E02}}; tx[2] = 20'h08421;
    ta[3] = ta[1]; tb[3] = tb[1]; tr[3] = 3'd3;
    te_dyn[3] = {4{16'h3E03}}; te_rne[3] = {4{16'h3E02}}; tx[3] = 20'h08421;
    ta[4] = 64'h7E01_0200_0000_7DFF; tb[4] = 64'h3C00_3C00_7E00_4000; tr[4] = 3'd0;
    te_dyn[4] = 64'h7FFF_0000_7FFF_7E00; te_rne[4] = te_dyn[4]; tx[4] = 20'h00E05;
    ta[5] = 64'hFE00_0200_0000_7DFF; tb[5] = tb[4]; tr[5] = 3'd1;
    te_dyn[5] = 64'hFE00_0000_7FFF_7DFF; te_rne[5] = 64'hFE00_0000_7FFF_7E00;
    tx[5] = 20'h00E05;
    out_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      if (r == 4) pulse_clr();
      push(ta[r], tb[r], tr[r], 8'(8'h10 + r));
      wait_out(lat);
      want = DYN ? te_dyn[r] : te_rne[r];
      n_cmp++;
      if (lat != 3) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d want 3", r, lat);
      end
      n_cmp++;
      if (out_res !== want) begin
        n_err++;
        $display("FAIL dir%0d_res: got %h want %h", r, out_res, want);
      end
      n_cmp++;
      if (out_excep !== tx[r]) begin
        n_err++;
        $display("FAIL dir%0d_excep: got %h want %h", r, out_excep, tx[r]);
      end
      n_cmp++;
      if (out_tag !== 8'(8'h10 + r)) begin
        n_err++;
        $display("FAIL dir%0d_tag: got %h want %h", r, out_tag, 8'(8'h10 + r));
      end
      @(posedge clk);
      @(negedge clk);
      if (r == 4) begin
        n_cmp++;
        if (fflags !== 5'b10111) begin
          n_err++;
          $display("FAIL dir4_fflags: got %b want 10111", fflags);
        end
      end
    end
  endtask

  task automatic test_flags_clr();
    int lat;
    out_ready = 1'b1;
    pulse_clr();
    push({{3{16'h3F00}}, 16'h0000}, {{3{16'h4000}}, 16'h7E00}, 3'd0, 8'h21);
    wait_out(lat);
    @(negedge clk);
    n_cmp++;
    if (fflags !== 5'b10000) begin
      n_err++;
      $display("FAIL flags_invalid: got %b want 10000", fflags);
    end
    push({4{16'h7DFF}}, {4{16'h4000}}, 3'd0, 8'h22);
    wait_out(lat);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    n_cmp++;
    if (fflags !== 5'b00101) begin
      n_err++;
      $display("FAIL flags_clr_with_delivery: got %b want 00101", fflags);
    end
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    n_cmp++;
    if (fflags !== 5'b00000) begin
      n_err++;
      $display("FAIL flags_clr_alone: got %b want 00000", fflags);
    end
  endtask

  // random_bp=0: fixed stall on cycles 4..7; random_bp=1: random back-pressure.
  task automatic test_stream(input int n, input bit random_bp);
    sb_t q[$];
    logic [63:0] pa, pb;
    logic [2:0]  prm;
    logic [7:0]  ptag;
    logic [4:0]  acc;
    bit have;
    int sent, got, cyc;
    acc = '0;
    have = 1'b0;
    sent = 0;
    got = 0;
    cyc = 0;
    pa = '0; pb = '0; prm = '0; ptag = '0;
    out_ready = 1'b1;
    pulse_clr();
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      if (!have && sent < n) begin
        for (int i = 0; i < 4; i++) begin
          pa[16*i +: 16] = rand_op();
          pb[16*i +: 16] = rand_op();
        end
        prm  = 3'($urandom_range(0, 7));
        ptag = 8'($urandom);
        have = 1'b1;
      end
      in_valid  = have;
      in_a      = pa;
      in_b      = pb;
      in_rm     = prm;
      in_tag    = ptag;
      out_ready = random_bp ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 7);
      #1;
      if (!random_bp && cyc >= 4 && cyc <= 7) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stall_in_ready cyc%0d: got %b want 0", cyc, in_ready);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL stream_spurious cyc%0d: got out_valid=1 want 0", cyc);
        end else if (out_res !== q[0].res || out_excep !== q[0].exc || out_tag !== q[0].tag)
        begin
          n_err++;
          $display("FAIL stream_out cyc%0d: got res=%h exc=%h tag=%h want res=%h exc=%h tag=%h",
                   cyc, out_res, out_excep, out_tag, q[0].res, q[0].exc, q[0].tag);
        end
        if (out_ready && q.size() != 0) begin
          acc = acc | q[0].exc[4:0] | q[0].exc[9:5] | q[0].exc[14:10] | q[0].exc[19:15];
          void'(q.pop_front());
          got++;
        end
      end
      if (have && in_ready) begin
        q.push_back(ref_bundle(pa, pb, prm, ptag));
        sent++;
        have = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != n) begin
      n_err++;
      $display("FAIL stream_timeout: got %0d delivered want %0d", got, n);
    end
    @(negedge clk);
    n_cmp++;
    if (fflags !== acc) begin
      n_err++;
      $display("FAIL stream_fflags: got %b want %b", fflags, acc);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_duplicate: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    out_ready = 1'b1;
    pulse_clr();
    push({4{16'h3E01}}, {4{16'h3E01}}, 3'd0, 8'h31);
    wait_out(lat);
    @(negedge clk);
    n_cmp++;
    if (fflags !== 5'b00001) begin
      n_err++;
      $display("FAIL preflight_fflags: got %b want 00001", fflags);
    end
    push({4{16'h3F00}}, {4{16'h4000}}, 3'd0, 8'h32);
    push({4{16'h7DFF}}, {4{16'h4000}}, 3'd0, 8'h33);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, fflags, out_res, out_tag, out_excep} !== '0) begin
      n_err++;
      $display("FAIL midflight_reset: got v=%b ff=%b res=%h tag=%h exc=%h want all zero",
               out_valid, fflags, out_res, out_tag, out_excep);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || fflags !== 5'd0) begin
        n_err++;
        $display("FAIL post_reset_stale c%0d: got v=%b ff=%b want 0/0", c, out_valid, fflags);
      end
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_rm     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    flags_clr = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_directed();
    test_flags_clr();
    test_stream(6, 1'b0);
    test_stream(300, 1'b1);
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
